// File: rtl/mux_8x1_rr.sv
// rtl/mux_8x1_rr.sv - 8-to-1 valid/ready stream merge with round-robin arbitration
// One output register stage; ptr names the highest-priority channel.
module mux_8x1_rr #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_valid,
  input  logic [8*DATA_W-1:0]   in_data,
  output logic [7:0]            in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [2:0]            out_sel,
  input  logic                  out_ready,
  output logic [15:0]           xfer_count
);

  logic [2:0]        ptr;
  logic [2:0]        gnt_idx;
  logic [2:0]        idx;
  logic              any_req;
  logic              free;
  logic              in_xfer;
  logic              out_xfer;
  logic [DATA_W-1:0] gnt_data;

  // Scan from lowest priority to highest so the highest-priority requester wins last.
  always_comb begin
    gnt_idx = ptr;
    idx     = ptr;
    any_req = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (in_valid[idx]) begin
        gnt_idx = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data = in_data[DATA_W-1:0];
    for (int k = 0; k < 8; k++) begin
      if (3'(k) == gnt_idx) gnt_data = in_data[k*DATA_W +: DATA_W];
    end
  end

  assign free     = !out_valid || out_ready;
  // in_ready is gated by rst_n so it reads zero for the whole reset assertion.
  assign in_xfer  = rst_n && free && any_req;
  assign in_ready = in_xfer ? (8'b1 << gnt_idx) : 8'b0;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= 3'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 3'd0;
      xfer_count <= 16'd0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= gnt_data;
        out_sel   <= gnt_idx;
        ptr       <= gnt_idx + 3'd1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer) xfer_count <= xfer_count + 16'd1;
    end
  end

endmodule

// File: doc/mux_8x1_rr.md
MUX_8X1_RR -- requirements
Module: mux_8x1_rr

Interface
REQ-001 Parameter DATA_W, default 8, is the width of each channel's data word.
REQ-002 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 in_valid  input  8  gives per-channel valid; bit i belongs to channel i.
REQ-005 in_data  input  8*DATA_W  carries the channel words; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-006 in_ready  output  8  is the per-channel ready; at most one bit is high in any cycle.
REQ-007 out_valid  output  1  is high while the output register holds a word.
REQ-008 out_data  output  DATA_W  is the registered output word.
REQ-009 out_sel  output  3  is the source channel index of out_data.
REQ-010 out_ready  input  1  is the downstream accept.
REQ-011 xfer_count  output  16  counts completed output transfers.

Function
REQ-012 The block SHALL merge 8 valid/ready input streams into one output stream through one output register stage, arbitrating round-robin.
REQ-013 The internal pointer ptr (3 bits) SHALL name the highest-priority channel; priority falls in order ptr, ptr+1, ..., ptr+7 mod 8.
REQ-014 The output register is "free" when out_valid==0, or when out_valid==1 and out_ready==1 in the same cycle.
REQ-015 When free and any in_valid bit is high, the block SHALL grant the first requesting channel g in priority order, and drive in_ready[g]=1 combinationally in that cycle.
REQ-016 When not free, or when no in_valid bit is high, in_ready SHALL be 8'b0.
REQ-017 An input transfer occurs when in_valid[g] & in_ready[g]; on that edge out_data<=word g, out_sel<=g, out_valid<=1 and ptr<=g+1 mod 8 (7 wraps to 0).
REQ-018 Latency SHALL be 1 cycle from input transfer to out_valid; full throughput (one word per cycle) SHALL hold while out_ready stays high.
REQ-019 An output transfer occurs when out_valid & out_ready; if no input transfer occurs on the same edge, out_valid<=0 and out_data/out_sel hold their last values.
REQ-020 A simultaneous output transfer and input transfer SHALL replace the register contents with no bubble.
REQ-021 While out_valid==1 and out_ready==0, out_data, out_sel and out_valid SHALL remain stable.
REQ-022 ptr SHALL change only on an input transfer.
REQ-023 A channel whose in_valid drops before it is granted SHALL simply lose arbitration; no request is latched.
REQ-024 xfer_count SHALL increment by 1 on each output transfer, wrapping from 16'hFFFF to 0.
REQ-025 in_data of non-granted channels SHALL have no effect on any output.
REQ-026 With all 8 channels continuously valid and out_ready=1, grants SHALL occur in the sequence ptr, ptr+1, ... with no channel starved for more than 7 consecutive grants.

Reset
REQ-027 While rst_n==0, the outputs SHALL be: out_valid=0, out_data=0, out_sel=0, xfer_count=0, in_ready=8'b0; ptr SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held word immediately, without waiting for a clock edge.
REQ-029 After rst_n rises, the first grant SHALL follow the priority order from ptr=0.

Verification
REQ-030 Reset, then in_valid=8'h01, in_data channel0=8'hA5, out_ready=1 -> in_ready=8'h01; next cycle out_valid=1, out_data=8'hA5, out_sel=0; xfer_count=1 one cycle later.
REQ-031 After reset, in_valid=8'hFF held, out_ready=1 for 10 cycles -> out_sel sequence 0,1,2,...,7,0,1 with out_valid continuously 1.
REQ-032 With out_valid=1 and out_sel=3, out_ready=0 for 4 cycles while in_valid=8'hFF -> in_ready=0, out_data and out_sel stable; on out_ready=1 the next grant is channel 4.
REQ-033 With ptr=6 and in_valid=8'b0000_0011 -> channel 0 is granted and ptr becomes 1; next grant is channel 1.
REQ-034 Hold rst_n=0 asynchronously mid-stream with out_valid=1 -> out_valid=0, xfer_count=0 and in_ready=0 immediately; after release with in_valid=8'h80, the grant goes to channel 7.
REQ-035 Preload xfer_count to 16'hFFFF via 65535 transfers, then perform one more transfer -> xfer_count=16'h0000.
